// File: rtl/uart_tx_frame_if.sv
// Handshake bundle between a frame producer and the UART transmitter: request,
// word, per-frame format, and the ready/done status coming back.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] din;
    logic [1:0]            parity_mode;
    logic                  stop_bits;
    logic                  tx_ready;
    logic                  tx_done_tick;

    modport master (
        output tx_start, din, parity_mode, stop_bits,
        input  tx_ready, tx_done_tick
    );

    modport slave (
        input  tx_start, din, parity_mode, stop_bits,
        output tx_ready, tx_done_tick
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity and
// one or two stop bits, with the frame format latched when a request is accepted.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int TIME       = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_tick,
    uart_tx_frame_if.slave bus,
    output logic           tx
);
    localparam int TW = $clog2(TIME);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TIME - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                state_r, state_next_s;
    logic [TW-1:0]         tick_r, tick_next_s;
    logic [BW-1:0]         bit_r, bit_next_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_next_s;
    logic                  par_bit_r, par_bit_next_s;
    logic                  par_en_r, par_en_next_s;
    logic                  two_stop_r, two_stop_next_s;
    logic                  bit_end_s, frame_end_s;
    logic                  tx_r, tx_next_s;
    logic                  ready_r, ready_next_s;
    logic                  done_r, done_next_s;

    // State and datapath register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            tick_r     <= {TW{1'b0}};
            bit_r      <= {BW{1'b0}};
            shift_r    <= {DATA_WIDTH{1'b0}};
            par_bit_r  <= 1'b0;
            par_en_r   <= 1'b0;
            two_stop_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tick_r     <= tick_next_s;
            bit_r      <= bit_next_s;
            shift_r    <= shift_next_s;
            par_bit_r  <= par_bit_next_s;
            par_en_r   <= par_en_next_s;
            two_stop_r <= two_stop_next_s;
        end
    end

    // Next-state logic: tick/bit counters, shifter and per-frame format latch
    always_comb begin
        state_next_s    = state_r;
        bit_next_s      = bit_r;
        shift_next_s    = shift_r;
        par_bit_next_s  = par_bit_r;
        par_en_next_s   = par_en_r;
        two_stop_next_s = two_stop_r;
        frame_end_s     = 1'b0;
        bit_end_s       = s_tick && (tick_r == TICK_LAST);
        if (s_tick) begin
            tick_next_s = bit_end_s ? {TW{1'b0}} : tick_r + TW'(1);
        end else begin
            tick_next_s = tick_r;
        end
        case (state_r)
            ST_IDLE: begin
                // Counters are held clear so the tick seen on the accept edge is not counted
                tick_next_s = {TW{1'b0}};
                bit_next_s  = {BW{1'b0}};
                if (bus.tx_start) begin
                    state_next_s    = ST_START;
                    shift_next_s    = bus.din;
                    par_en_next_s   = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                    par_bit_next_s  = calc_parity(bus.din, bus.parity_mode == 2'b10);
                    two_stop_next_s = bus.stop_bits;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_next_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
                    if (bit_r == BIT_LAST) begin
                        bit_next_s   = {BW{1'b0}};
                        state_next_s = par_en_r ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next_s = bit_r + BW'(1);
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_next_s = ST_STOP;
                    bit_next_s   = {BW{1'b0}};
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // bit_r doubles as the stop-bit index
                if (bit_end_s) begin
                    if (two_stop_r && (bit_r == {BW{1'b0}})) begin
                        bit_next_s = BW'(1);
                    end else begin
                        state_next_s = ST_IDLE;
                        frame_end_s  = 1'b1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so tx/ready/done can be registered
    always_comb begin
        tx_next_s    = 1'b1;
        ready_next_s = (state_next_s == ST_IDLE);
        done_next_s  = frame_end_s;
        case (state_next_s)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
            ST_PARITY: tx_next_s = par_bit_next_s;
            ST_STOP:   tx_next_s = 1'b1;
            ST_IDLE:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            tx_r    <= tx_next_s;
            ready_r <= ready_next_s;
            done_r  <= done_next_s;
        end
    end

    assign tx               = tx_r;
    assign bus.tx_ready     = ready_r;
    assign bus.tx_done_tick = done_r;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: reset, 8N1/8E2/8O1 framing, sparse ticks,
// back-to-back frames and reset in mid-frame.
module tb_uart_tx_frame;
    logic        clk;
    logic        reset;
    logic        s_tick;
    logic        tx;
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          tick_div = 1;
    int          done_cnt = 0;
    int          d0       = 0;
    logic        disturb  = 1'b0;
    logic [11:0] fbits;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8), .TIME(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick),
        .bus    (bus),
        .tx     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, schedule s_tick for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.tx_done_tick === 1'b1) done_cnt++;
        s_tick = (tick_div == 1) ? 1'b1 : (((cyc + 1) % tick_div) == 0);
    endtask

    // Present a request so the accept edge also carries a (discarded) tick.
    task automatic accept(input logic [7:0] d, input logic [1:0] pm, input logic sb);
        if (tick_div != 1) begin
            while (((cyc + 1) % tick_div) != 0) step();
        end
        bus.din         = d;
        bus.parity_mode = pm;
        bus.stop_bits   = sb;
        bus.tx_start    = 1'b1;
        step();
    endtask

    // Called just after the accept edge; ends just after the final-tick edge.
    task automatic check_frame(input logic [11:0] bits, input int n, input int tclk, input string tag);
        logic b;
        for (int idx = 0; idx < n * tclk; idx++) begin
            b = bits[4'(idx / tclk)];
            chk({tag, " tx"}, 32'(tx), 32'(b));
            if (idx == 0 || idx == n * tclk - 1) chk({tag, " ready busy"}, 32'(bus.tx_ready), 32'd0);
            if (disturb && idx == 200) begin
                bus.tx_start    = 1'b1;
                bus.din         = 8'h00;
                bus.parity_mode = 2'b10;
                bus.stop_bits   = 1'b1;
            end
            if (disturb && idx == 260) bus.tx_start = 1'b0;
            step();
        end
        chk({tag, " done"}, 32'(bus.tx_done_tick), 32'd1);
        chk({tag, " ready end"}, 32'(bus.tx_ready), 32'd1);
        chk({tag, " tx idle"}, 32'(tx), 32'd1);
    endtask

    initial begin
        reset           = 1'b0;
        s_tick          = 1'b0;
        bus.tx_start    = 1'b0;
        bus.din         = 8'h00;
        bus.parity_mode = 2'b00;
        bus.stop_bits   = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            step();
            bus.tx_start    = 1'($urandom);
            bus.din         = 8'($urandom);
            bus.parity_mode = 2'($urandom);
            bus.stop_bits   = 1'($urandom);
            s_tick          = 1'($urandom);
            chk("reset tx", 32'(tx), 32'd1);
            chk("reset ready", 32'(bus.tx_ready), 32'd1);
            chk("reset done", 32'(bus.tx_done_tick), 32'd0);
        end
        bus.tx_start = 1'b0;
        reset        = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle outputs", 32'({tx, bus.tx_ready, bus.tx_done_tick}), 32'd6);
        end

        // 8N1, din A5
        d0 = done_cnt;
        accept(8'hA5, 2'b00, 1'b0);
        bus.tx_start = 1'b0;
        fbits = {2'b00, 1'b1, 8'hA5, 1'b0};
        check_frame(fbits, 10, 16, "8N1");
        step();
        chk("8N1 done low", 32'(bus.tx_done_tick), 32'd0);
        chk("8N1 pulses", 32'(done_cnt - d0), 32'd1);

        // 8E2, din 07: parity 1, two stop bits
        accept(8'h07, 2'b01, 1'b1);
        bus.tx_start = 1'b0;
        fbits = {1'b1, 1'b1, 1'b1, 8'h07, 1'b0};
        check_frame(fbits, 12, 16, "8E2");
        step();

        // 8O1, din 07: parity 0
        accept(8'h07, 2'b10, 1'b0);
        bus.tx_start = 1'b0;
        fbits = {1'b0, 1'b1, 1'b0, 8'h07, 1'b0};
        check_frame(fbits, 11, 16, "8O1");
        step();

        // parity_mode 11 behaves as none
        accept(8'h07, 2'b11, 1'b0);
        bus.tx_start = 1'b0;
        fbits = {2'b00, 1'b1, 8'h07, 1'b0};
        check_frame(fbits, 10, 16, "8N1 pm11");
        step();

        // Sparse ticks every 4th clock with mid-frame disturbance
        tick_div = 4;
        accept(8'h3C, 2'b00, 1'b0);
        bus.tx_start = 1'b0;
        disturb = 1'b1;
        fbits = {2'b00, 1'b1, 8'h3C, 1'b0};
        check_frame(fbits, 10, 64, "sparse");
        disturb = 1'b0;
        step();
        chk("sparse done low", 32'(bus.tx_done_tick), 32'd0);

        // Back-to-back frames with tx_start held high
        tick_div = 1;
        d0 = done_cnt;
        accept(8'h55, 2'b00, 1'b0);
        bus.din = 8'hAA;
        fbits = {2'b00, 1'b1, 8'h55, 1'b0};
        check_frame(fbits, 10, 16, "b2b first");
        step();
        bus.tx_start = 1'b0;
        fbits = {2'b00, 1'b1, 8'hAA, 1'b0};
        check_frame(fbits, 10, 16, "b2b second");
        step();
        chk("b2b pulses", 32'(done_cnt - d0), 32'd2);

        // Reset during data bit 3
        accept(8'h81, 2'b00, 1'b0);
        bus.tx_start = 1'b0;
        for (int i = 0; i < 70; i++) step();
        chk("pre-reset tx bit3", 32'(tx), 32'd0);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("async reset tx", 32'(tx), 32'd1);
        chk("async reset ready", 32'(bus.tx_ready), 32'd1);
        chk("async reset done", 32'(bus.tx_done_tick), 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("no partial done", 32'(done_cnt - d0), 32'd0);
        chk("post-reset idle tx", 32'(tx), 32'd1);
        accept(8'hFF, 2'b00, 1'b0);
        bus.tx_start = 1'b0;
        fbits = {2'b00, 1'b1, 8'hFF, 1'b0};
        check_frame(fbits, 10, 16, "after reset FF");
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: the next generation of the team's fixed-format transmitter. It serialises a DATA_WIDTH-bit word LSB-first as start bit, data bits, an optional parity bit and one or two stop bits. Each bit lasts TIME oversampling ticks from the shared baud-tick generator. Frame format is selected per frame at accept time, and a ready/start handshake makes back-to-back frames deterministic.

## Interface
- DATA_WIDTH, 8, data bits per frame (legal 5..9)
- TIME, 16, s_tick pulses per bit (legal ≥2)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; all state cleared while low
- s_tick  input  1  one-clk-wide oversampling tick from baud generator
- tx_start  input  1  request to send din; accepted only when tx_ready=1
- din  input  DATA_WIDTH  word to send, latched at accept
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; latched at accept
- stop_bits  input  1  0 = one stop bit, 1 = two; latched at accept
- tx_ready  output  1  high in IDLE; reset value 1
- tx_done_tick  output  1  one-clk pulse at end of frame; reset value 0
- tx  output  1  serial line, registered, idle high; reset value 1

## Operation
- States: IDLE, START, DATA, PARITY, STOP. All outputs come straight from registers (no combinational path from inputs to tx).
- IDLE
  - tx=1, tx_ready=1.
  - On tx_start=1, latch din into the shift register and latch parity_mode and stop_bits.
  - Compute the parity bit = ^din for even, ~^din for odd. Store it.
  - Clear the tick counter and bit counter, then go to START.
- START: tx=0 for TIME ticks, then go to DATA.
- DATA
  - tx=shift[0] for TIME ticks per bit, then shift right.
  - After the DATA_WIDTH-th bit, go to PARITY if parity is enabled, else go to STOP.
- PARITY: tx=stored parity bit for TIME ticks, then go to STOP.
- STOP
  - tx=1 for TIME ticks per stop bit, with one or two stop bits.
  - After the last stop bit, go to IDLE and pulse tx_done_tick.
- Tick counter width is $clog2(TIME) bits and saturation-free. Its terminal value is TIME-1.
  - A bit ends on an edge where s_tick=1 and the counter equals TIME-1. The counter returns to 0 on that edge.
  - The counter advances only on edges where s_tick=1.
- Bit counter width is $clog2(DATA_WIDTH+1). It is also reused as the stop-bit index.
- tx_start while tx_ready=0 is ignored: no queueing, and no effect on the frame in flight.
- din, parity_mode and stop_bits changing mid-frame have no effect.
- Reset asserted mid-frame: tx goes to 1 and state to IDLE immediately (asynchronously). tx_ready goes to 1 and tx_done_tick to 0. No partial-frame done pulse.

## Timing
- Accept occurs on edge k (tx_start=1, tx_ready=1).
  - After edge k: tx=0 and tx_ready=0.
  - s_tick sampled at edge k is not counted. The first counted tick is at edge k+1 or later.
- Frame length N = 1 + DATA_WIDTH + P + S bits, where P ∈ {0,1} and S ∈ {1,2}. The frame spans N·TIME counted ticks.
- On the edge carrying the final counted tick:
  - State returns to IDLE.
  - tx_done_tick=1 and tx_ready=1 for exactly the following clock cycle.
- Back-to-back: tx_start=1 during the tx_done_tick cycle is accepted on that cycle's closing edge. The next start bit follows with zero idle cycles between the stop bit and the next start bit.
- With s_tick=1 every clock, tx_done_tick is high in the cycle after edge k+N·TIME.
- Each bit boundary on tx is aligned to the clock edge that consumed the terminal tick.

## Test plan
- Reset: hold reset=0 with random inputs -> tx=1, tx_ready=1, tx_done_tick=0. Release, leave tx_start=0 for 100 cycles -> outputs unchanged.
- 8N1: DATA_WIDTH=8, TIME=16, s_tick every clock, din=8'hA5, parity_mode=00, stop_bits=0.
  - tx sequence at 16 clocks per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - Single done pulse in the cycle after edge k+160.
- 8E2 / 8O1: din=8'h07 (three ones).
  - Even, two stop bits -> parity bit 1, two stop bits of 16 ticks each, done at k+192.
  - Odd -> parity bit 0.
- Sparse ticks: s_tick every 4th clock, din=8'h3C, 8N1 -> each bit held 64 clocks. tx_start pulses mid-frame are ignored, and din changes have no effect.
- Back-to-back: assert tx_start continuously with din=8'h55 then 8'hAA -> second start bit begins exactly one clock after the done cycle, with no extra idle. Two done pulses in total.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately, no done pulse. After release, a new frame with din=8'hFF transmits correctly.
